fnd_sum_display: RTL
====================

Name: fnd_sum_display

Overview:
Downstream consumer of the full-adder chain. Captures a completed 8-bit sum plus carry-out (a 9-bit value, 0..511) and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. Drives a 4-digit multiplexed common-anode seven-segment (FND) display, with leading-zero blanking. It is the display stage between the adder datapath and the board FND pins.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2; bench uses 4.

Ports:
i_clk  input  1  system clock; all logic on the rising edge.
i_reset  input  1  synchronous, active-high reset.
i_valid  input  1  one-cycle strobe: i_sum/i_carry hold a new result.
i_sum  input  8  adder sum bits.
i_carry  input  1  adder carry-out; value = {i_carry, i_sum}.
o_busy  output  1  high while a conversion is in progress.
o_bcd  output  16  last converted value, 4 BCD nibbles {thousands, hundreds, tens, ones}.
o_fnd_com  output  4  digit select, active-low; bit0 = ones digit.
o_fnd_font  output  8  segments, active-low; bit0..6 = a..g, bit7 = dp (always 1/off).

Behaviour:
- Reset (synchronous, active-high) forces: FSM=IDLE, o_busy=0, o_bcd=16'h0000, tick counter=0, digit index=0, o_fnd_com=4'b1110, o_fnd_font=8'hC0. A reset asserted mid-conversion aborts it; no partial result is stored.
- Conversion FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if i_valid=1, load the 9-bit shift register with {i_carry, i_sum}, clear the 16-bit scratch, set bit counter=9, set o_busy=1, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, shiftreg} left by 1 and decrement the counter. After the 9th shift, go to DONE.
  - DONE: copy scratch to o_bcd, clear o_busy, go to IDLE.
- Timing: i_valid sampled at edge N gives o_busy=1 from edge N through edge N+10, where it falls. o_bcd updates on that same edge N+10. o_busy is high for exactly 10 cycles.
- i_valid while o_busy=1 is ignored; there is no queueing. i_valid in the same cycle that DONE completes is also ignored. A new capture is possible from the cycle after o_busy falls.
- o_bcd holds its value between conversions. The maximum value 511 gives 16'h0511, so the thousands nibble is always 0.
- Scan:
  - The tick counter runs freely 0..SCAN_DIV-1 and wraps.
  - On each wrap, the digit index advances 0->1->2->3->0.
  - Scanning never stops; it shows the old o_bcd during a conversion.
- o_fnd_com and o_fnd_font are registered. They reflect the current digit index and o_bcd with one cycle of latency.
  - Digit selects: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
- Font map (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 blank=FF.
- Leading-zero blanking:
  - Thousands is always blank.
  - Hundreds is blank if its nibble is 0.
  - Tens is blank if both hundreds and tens are 0.
  - Ones is always shown.
  - The common line is still driven for blanked digits; only the font is FF.

Test Plan:
1. Reset held 2 cycles, then released -> o_busy=0, o_bcd=0000, o_fnd_com=1110, o_fnd_font=C0; these hold until the first scan wrap.
2. i_carry=1, i_sum=8'hFF, i_valid pulse -> o_busy high exactly 10 cycles; o_bcd=16'h0511 on the falling edge of o_busy; scan fonts ones=F9, tens=F9, hundreds=92, thousands=FF.
3. i_sum=8'd7, i_carry=0 (SCAN_DIV=4) -> o_bcd=0007; over one full scan, com 1110/font F8, 1101/FF, 1011/FF, 0111/FF, each held 4 cycles.
4. i_sum=8'd100, i_carry=0 -> o_bcd=0100; tens shows C0 (not blanked), hundreds F9, ones C0, thousands FF.
5. Convert 8'd42; pulse i_valid with 8'd99 on cycle 3 of o_busy -> o_bcd=0042, o_busy not extended, the second value is never captured.
6. Start converting 511; assert i_reset on cycle 5 of SHIFT -> next cycle o_busy=0, o_bcd=0000, com=1110. A subsequent i_valid with 8'd200 gives o_bcd=0200 after 10 cycles.

Source files
------------

// File: rtl/fnd_sum_display.sv
// ---------------------------------------------------------------------------
// fnd_sum_display
//
// Display stage between the full-adder chain and the board FND pins.
// A 9-bit result {carry, sum} (0..511) is captured on a valid strobe and
// converted to BCD by a sequential shift-add-3 (double-dabble) engine. The
// last converted value is scanned onto a 4-digit multiplexed common-anode
// seven-segment display, with leading zeros blanked.
//
// Parameters:
//   SCAN_DIV    clock cycles per digit slot (>= 2)
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_valid     one-cycle strobe, i_sum/i_carry hold a new result
//   i_sum       adder sum bits
//   i_carry     adder carry-out, value = {i_carry, i_sum}
//   o_busy      high while a conversion is in progress (10 cycles)
//   o_bcd       last converted value {thousands, hundreds, tens, ones}
//   o_fnd_com   digit select, active-low, bit0 = ones digit
//   o_fnd_font  segments a..g on bits 0..6, dp on bit 7, active-low
// ---------------------------------------------------------------------------
module fnd_sum_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [7:0]  i_sum,
    input  logic        i_carry,
    output logic        o_busy,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
    // that the following doubling carries correctly into the next decade.
    function automatic logic [15:0] add3_all(input logic [15:0] value);
        logic [15:0] result;
        result = value;
        for (int i = 0; i < 4; i++) begin
            if (value[i*4 +: 4] >= 4'd5) begin
                result[i*4 +: 4] = value[i*4 +: 4] + 4'd3;
            end else begin
                result[i*4 +: 4] = value[i*4 +: 4];
            end
        end
        return result;
    endfunction

    // Active-low seven-segment pattern for one BCD digit; non-decimal codes
    // cannot occur but are mapped to a dark digit.
    function automatic logic [7:0] seg_font(input logic [3:0] digit);
        logic [7:0] font;
        case (digit)
            4'd0:    font = 8'hC0;
            4'd1:    font = 8'hF9;
            4'd2:    font = 8'hA4;
            4'd3:    font = 8'hB0;
            4'd4:    font = 8'h99;
            4'd5:    font = 8'h92;
            4'd6:    font = 8'h82;
            4'd7:    font = 8'hF8;
            4'd8:    font = 8'h80;
            4'd9:    font = 8'h90;
            default: font = 8'hFF;
        endcase
        return font;
    endfunction

    // Active-low common line for a digit slot.
    function automatic logic [3:0] com_sel(input logic [1:0] index);
        logic [3:0] com;
        case (index)
            2'd0:    com = 4'b1110;
            2'd1:    com = 4'b1101;
            2'd2:    com = 4'b1011;
            2'd3:    com = 4'b0111;
            default: com = 4'b1110;
        endcase
        return com;
    endfunction

    // -----------------------------------------------------------------------
    // Conversion engine state
    // -----------------------------------------------------------------------
    state_t        state_r;
    state_t        state_next_s;
    logic [8:0]    shift_r;
    logic [8:0]    shift_next_s;
    logic [15:0]   scratch_r;
    logic [15:0]   scratch_next_s;
    logic [3:0]    bit_cnt_r;
    logic [3:0]    bit_cnt_next_s;
    logic          busy_r;
    logic          busy_next_s;
    logic [15:0]   bcd_r;
    logic [15:0]   bcd_next_s;
    logic [15:0]   adjusted_s;
    logic [24:0]   shifted_s;

    // Conversion FSM next-state and datapath logic.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        scratch_next_s = scratch_r;
        bit_cnt_next_s = bit_cnt_r;
        busy_next_s    = busy_r;
        bcd_next_s     = bcd_r;
        adjusted_s     = add3_all(scratch_r);
        // The MSB of the corrected scratch falls off the top; it is always 0
        // for inputs up to 511.
        shifted_s      = {adjusted_s, shift_r} << 1;

        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    shift_next_s   = {i_carry, i_sum};
                    scratch_next_s = 16'h0000;
                    bit_cnt_next_s = 4'd9;
                    busy_next_s    = 1'b1;
                    state_next_s   = ST_SHIFT;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scratch_next_s = shifted_s[24:9];
                shift_next_s   = shifted_s[8:0];
                bit_cnt_next_s = bit_cnt_r - 4'd1;
                if (bit_cnt_r == 4'd1) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // A strobe arriving here is deliberately dropped.
                bcd_next_s   = scratch_r;
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 9'd0;
            scratch_r <= 16'h0000;
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b0;
            bcd_r     <= 16'h0000;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            scratch_r <= scratch_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            busy_r    <= busy_next_s;
            bcd_r     <= bcd_next_s;
        end
    end

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------
    logic [TICK_W-1:0] tick_r;
    logic [1:0]        digit_r;
    logic [3:0]        digit_nib_s;
    logic              blank_s;
    logic [3:0]        com_s;
    logic [7:0]        font_s;
    logic [3:0]        com_r;
    logic [7:0]        font_r;

    // Free-running slot timer; each wrap moves to the next digit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tick_r  <= '0;
            digit_r <= 2'd0;
        end else if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            digit_r <= digit_r + 2'd1;
        end else begin
            tick_r  <= tick_r + TICK_W'(1);
            digit_r <= digit_r;
        end
    end

    // Digit selection with leading-zero blanking; ones is never blanked so
    // a zero result still shows a single 0.
    always_comb begin
        digit_nib_s = 4'd0;
        blank_s     = 1'b0;
        com_s       = com_sel(digit_r);
        case (digit_r)
            2'd0: begin
                digit_nib_s = bcd_r[3:0];
                blank_s     = 1'b0;
            end
            2'd1: begin
                digit_nib_s = bcd_r[7:4];
                blank_s     = (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
            end
            2'd2: begin
                digit_nib_s = bcd_r[11:8];
                blank_s     = (bcd_r[11:8] == 4'd0);
            end
            2'd3: begin
                digit_nib_s = bcd_r[15:12];
                blank_s     = 1'b1;
            end
            default: begin
                digit_nib_s = 4'd0;
                blank_s     = 1'b1;
            end
        endcase
        if (blank_s) begin
            font_s = 8'hFF;
        end else begin
            font_s = seg_font(digit_nib_s);
        end
    end

    // Registered pin drivers, one cycle behind the digit index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            com_r  <= 4'b1110;
            font_r <= 8'hC0;
        end else begin
            com_r  <= com_s;
            font_r <= font_s;
        end
    end

    assign o_busy     = busy_r;
    assign o_bcd      = bcd_r;
    assign o_fnd_com  = com_r;
    assign o_fnd_font = font_r;

endmodule
